pwm_duty_ramp: RTL and testbench
================================

# pwm_duty_ramp

Setpoint stage that feeds the fractional PWM generator. Accepts a target duty in fixed-point PWM counts (integer plus FSZE fractional bits) over a valid/ready handshake. Slews the applied duty toward that target by at most one programmable step per PWM period, and clamps the target to a programmable ceiling. Presents the applied duty as an integer count `N` and a fractional word `mf`, and changes them only at PWM period boundaries so the downstream generator never sees a mid-period change.

## Interface
- `WIDTH`, 17, width of duty, step, limit and output words
- `FSZE`, 3, fractional bits; must equal the downstream generator's fractional width

Ports:
- `sys_clk`  in  1  single clock; all logic on rising edge
- `sync_rst`  in  1  reset, synchronous and active-high
- `period_tick`  in  1  one-cycle pulse at each PWM period boundary, from the downstream period counter
- `cmd_valid`  in  1  new target offered
- `cmd_ready`  out  1  block can accept a target
- `cmd_target`  in  WIDTH  target duty, unsigned, LSB = 1/2^FSZE count
- `cmd_step`  in  WIDTH  maximum change per period, same units; sampled with the target
- `duty_max`  in  WIDTH  ceiling, same units; sampled with the target
- `N`  out  WIDTH  integer part of applied duty
- `mf`  out  WIDTH  fractional word; bits [FSZE-1:0] hold the fraction, upper bits 0 (always non-negative)
- `clamped`  out  1  last accepted target exceeded `duty_max`
- `at_target`  out  1  applied duty equals latched target

## Operation
- Internal registers:
  - `cur`: WIDTH bits, applied duty
  - `tgt`, `step`: latched at accept
- Outputs:
  - `N = cur >> FSZE`, zero-extended
  - `mf = {0, cur[FSZE-1:0]}`
  - Both are registered and update in the same cycle as `cur`.
- State machine has three states: IDLE, LOAD, RAMP.
  - **IDLE:**
    - `cmd_ready=1`.
    - On `cmd_valid & cmd_ready`: latch `tgt = min(cmd_target, duty_max)` and `step = cmd_step`; set `clamped = (cmd_target > duty_max)`; go to LOAD.
  - **LOAD:**
    - `cmd_ready=0`; lasts one cycle.
    - If `tgt == cur`, return to IDLE; otherwise go to RAMP.
    - A `period_tick` during LOAD is ignored.
  - **RAMP:**
    - `cmd_ready=0`.
    - Each `period_tick`:
      - If `step == 0` or `|tgt - cur| <= step`, then `cur = tgt` and go to IDLE.
      - Otherwise `cur = cur + step` (when `tgt > cur`) or `cur = cur - step` (when `tgt < cur`).
    - Cycles without a tick hold all state.
- Arithmetic:
  - Difference and sum are computed at WIDTH+1 bits; `cur` never wraps and never passes `tgt`.
  - `tgt <= duty_max` always, so `cur <= duty_max` after convergence.
  - A `duty_max` smaller than the present `cur` simply ramps `cur` down.
- `at_target = (state == IDLE) & (cur == tgt)`.
- `cmd_valid` while `cmd_ready=0` is not accepted. The upstream source holds the command until ready; there is no buffering.

## Timing
- Reset (`sync_rst=1` at a clock edge) gives:
  - `cur = tgt = step = 0`, `N = 0`, `mf = 0`
  - `clamped = 0`, `at_target = 1`, state IDLE
  - `cmd_ready = 0` while `sync_rst` is high, and 1 on the first cycle after release
- Reset mid-RAMP: the outputs go to 0 at that edge, with no ramp down.
- Accept at edge k → LOAD during cycle k+1 → RAMP (or IDLE) from edge k+2.
- The first output change is on the edge that samples the first `period_tick` at or after edge k+2. `N`/`mf` are valid the following cycle, before the downstream generator's next period.
- One output change per tick, at most.
- Ticks in IDLE have no effect.
- `cmd_valid` and `period_tick` in the same IDLE cycle: the accept happens and the tick is ignored.
- Convergence takes `ceil(|tgt - cur0| / step)` ticks, where `cur0` is `cur` at accept.
- Back-to-back commands: the next accept is possible in the first IDLE cycle after convergence.

## Test plan
- **Reset values:** hold reset 3 cycles, then release → `N=0`, `mf=0`, `at_target=1`, `cmd_ready` rises on the cycle after release.
- **Ramp up:** target 0x50 (10.0), step 0x0C (1.5), `duty_max` 0x1FFFF, tick every 20 cycles → `cur` follows 12, 24, 36, 48, 60, 72, 80 over 7 ticks. The final word gives `N=10`, `mf=0`. At the 0x24 step, `N=4`, `mf=4`. `at_target=1` after the 7th tick.
- **Clamp:** target 0x200, `duty_max` 0x0F3, step 0 → `clamped=1`, and the first tick gives `N=0x1E`, `mf=3`.
- **Ramp down with non-aligned remainder:** from 0x50, target 0x03, step 0x20 → 0x30, 0x10, 0x03 on 3 ticks, with no undershoot.
- **Handshake:** assert `cmd_valid` during RAMP with target 0x10 → not accepted until IDLE; a tick coincident with accept is ignored; accept→LOAD→RAMP latency is exactly 2 edges.
- **Reset mid-ramp:** assert `sync_rst` halfway through the ramp-up case → `N=0`, `mf=0` on the next cycle, and the pending target is discarded.

Source files
------------

// File: rtl/pwm_duty_ramp_if.sv
// rtl/pwm_duty_ramp_if.sv - command handshake bundle for the duty ramp setpoint stage
`timescale 1ns/1ps
interface pwm_duty_ramp_if #(
    parameter int WIDTH = 17
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [WIDTH-1:0] cmd_target;
    logic [WIDTH-1:0] cmd_step;
    logic [WIDTH-1:0] duty_max;

    modport master (
        output cmd_valid,
        output cmd_target,
        output cmd_step,
        output duty_max,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_target,
        input  cmd_step,
        input  duty_max,
        output cmd_ready
    );
endinterface

// File: rtl/pwm_duty_ramp.sv
// rtl/pwm_duty_ramp.sv - slews applied PWM duty toward a clamped target, one step per period
`timescale 1ns/1ps
module pwm_duty_ramp #(
    parameter int WIDTH = 17,
    parameter int FSZE  = 3
) (
    input  logic             sys_clk,
    input  logic             sync_rst,
    input  logic             period_tick,
    pwm_duty_ramp_if.slave   cmd,
    output logic [WIDTH-1:0] N,
    output logic [WIDTH-1:0] mf,
    output logic             clamped,
    output logic             at_target
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RAMP = 2'd2
    } state_t;

    state_t           state, state_d;
    logic [WIDTH-1:0] cur, cur_d;
    logic [WIDTH-1:0] tgt, tgt_d;
    logic [WIDTH-1:0] step, step_d;
    logic             clamped_d;
    logic [WIDTH-1:0] n_d, mf_d;
    logic             up;
    logic [WIDTH:0]   diff;

    assign cmd.cmd_ready = (state == IDLE) && !sync_rst;
    assign at_target     = (state == IDLE) && (cur == tgt);

    assign up   = ({1'b0, tgt} > {1'b0, cur});
    assign diff = up ? ({1'b0, tgt} - {1'b0, cur}) : ({1'b0, cur} - {1'b0, tgt});

    always_comb begin
        state_d   = state;
        cur_d     = cur;
        tgt_d     = tgt;
        step_d    = step;
        clamped_d = clamped;
        case (state)
            IDLE: begin
                if (cmd.cmd_valid && cmd.cmd_ready) begin
                    tgt_d     = (cmd.cmd_target > cmd.duty_max) ? cmd.duty_max : cmd.cmd_target;
                    step_d    = cmd.cmd_step;
                    clamped_d = (cmd.cmd_target > cmd.duty_max);
                    state_d   = LOAD;
                end
            end
            LOAD: begin
                state_d = (tgt == cur) ? IDLE : RAMP;
            end
            RAMP: begin
                if (period_tick) begin
                    if ((step == '0) || (diff <= {1'b0, step})) begin
                        cur_d   = tgt;
                        state_d = IDLE;
                    end else begin
                        // diff > step here, so neither direction can wrap or overshoot tgt
                        cur_d = up ? (cur + step) : (cur - step);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        n_d  = cur_d >> FSZE;
        mf_d = {{(WIDTH-FSZE){1'b0}}, cur_d[FSZE-1:0]};
    end

    always_ff @(posedge sys_clk) begin
        if (sync_rst) begin
            state   <= IDLE;
            cur     <= '0;
            tgt     <= '0;
            step    <= '0;
            clamped <= 1'b0;
            N       <= '0;
            mf      <= '0;
        end else begin
            state   <= state_d;
            cur     <= cur_d;
            tgt     <= tgt_d;
            step    <= step_d;
            clamped <= clamped_d;
            N       <= n_d;
            mf      <= mf_d;
        end
    end
endmodule

// File: tb/tb_pwm_duty_ramp.sv
// tb/tb_pwm_duty_ramp.sv - randomized self-checking bench for pwm_duty_ramp
`timescale 1ns/1ps
module tb_pwm_duty_ramp;
    localparam int WIDTH = 17;
    localparam int FSZE  = 3;
    localparam int DMAX  = 'h1FFFF;

    logic             sys_clk = 1'b0;
    logic             sync_rst = 1'b1;
    logic             period_tick = 1'b0;
    logic [WIDTH-1:0] N, mf;
    logic             clamped, at_target;

    int checks = 0;
    int errors = 0;
    int model_cur = 0;

    pwm_duty_ramp_if #(.WIDTH(WIDTH)) cmd ();

    pwm_duty_ramp #(.WIDTH(WIDTH), .FSZE(FSZE)) dut (
        .sys_clk     (sys_clk),
        .sync_rst    (sync_rst),
        .period_tick (period_tick),
        .cmd         (cmd),
        .N           (N),
        .mf          (mf),
        .clamped     (clamped),
        .at_target   (at_target)
    );

    always #5 sys_clk = ~sys_clk;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Applied duty after k ticks of a ramp from c0 toward t in steps of s
    function automatic int exp_after(input int c0, input int t, input int s, input int k);
        if (s == 0) return t;
        if (t >= c0) return (c0 + k * s > t) ? t : c0 + k * s;
        return (c0 - k * s < t) ? t : c0 - k * s;
    endfunction

    function automatic int ticks_needed(input int c0, input int t, input int s);
        int d;
        d = (t > c0) ? t - c0 : c0 - t;
        if (d == 0) return 0;
        if (s == 0) return 1;
        return (d + s - 1) / s;
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    task automatic pulse_tick();
        period_tick = 1'b1;
        cyc(1);
        period_tick = 1'b0;
    endtask

    // Returns one cycle after the accepting edge (state LOAD)
    task automatic issue(input int t, input int s, input int m);
        bit ok;
        ok = 1'b0;
        cmd.cmd_valid  = 1'b1;
        cmd.cmd_target = WIDTH'(t);
        cmd.cmd_step   = WIDTH'(s);
        cmd.duty_max   = WIDTH'(m);
        for (int i = 0; i < 500; i++) begin
            if (cmd.cmd_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
            cyc(1);
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL issue_timeout: cmd_ready=%0b required 1 within 500 cycles", cmd.cmd_ready);
        end
        cyc(1);
        cmd.cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        sync_rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc(1);
            checks++;
            if (cmd.cmd_ready !== 1'b0) begin
                errors++;
                $display("FAIL reset_ready_low: got %0b required 0", cmd.cmd_ready);
            end
        end
        sync_rst = 1'b0;
        cyc(1);
        checks++;
        if (cmd.cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready_rise: got %0b required 1", cmd.cmd_ready);
        end
        checks++;
        if (N !== '0 || mf !== '0 || at_target !== 1'b1 || clamped !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: N=%0h mf=%0h at=%0b cl=%0b required 0 0 1 0", N, mf, at_target, clamped);
        end
        model_cur = 0;
    endtask

    task automatic test_ramp_up();
        int e;
        issue('h50, 'h0C, DMAX);
        for (int k = 1; k <= 7; k++) begin
            cyc(19);
            pulse_tick();
            e = exp_after(0, 'h50, 'h0C, k);
            checks++;
            if (N !== WIDTH'(e >> FSZE) || mf !== WIDTH'(e % 8)) begin
                errors++;
                $display("FAIL ramp_up_step%0d: N=%0h mf=%0h required N=%0h mf=%0h", k, N, mf, e >> FSZE, e % 8);
            end
            checks++;
            if (at_target !== (k == 7)) begin
                errors++;
                $display("FAIL ramp_up_at_target%0d: got %0b required %0b", k, at_target, k == 7);
            end
            if (k == 3) begin
                checks++;
                if (N !== 17'd4 || mf !== 17'd4) begin
                    errors++;
                    $display("FAIL ramp_up_0x24: N=%0d mf=%0d required 4 4", N, mf);
                end
            end
        end
        checks++;
        if (N !== 17'd10 || mf !== 17'd0) begin
            errors++;
            $display("FAIL ramp_up_final: N=%0d mf=%0d required 10 0", N, mf);
        end
        model_cur = 'h50;
    endtask

    task automatic test_clamp();
        issue('h200, 0, 'hF3);
        checks++;
        if (clamped !== 1'b1) begin
            errors++;
            $display("FAIL clamp_flag: got %0b required 1", clamped);
        end
        cyc(1);
        pulse_tick();
        checks++;
        if (N !== 17'h1E || mf !== 17'd3) begin
            errors++;
            $display("FAIL clamp_value: N=%0h mf=%0h required 1e 3", N, mf);
        end
        model_cur = 'hF3;
    endtask

    task automatic test_ramp_down();
        int exp_seq[3];
        exp_seq = '{'h30, 'h10, 'h03};
        issue('h50, 0, DMAX);
        checks++;
        if (clamped !== 1'b0) begin
            errors++;
            $display("FAIL down_unclamped: got %0b required 0", clamped);
        end
        cyc(1);
        pulse_tick();
        issue('h03, 'h20, DMAX);
        for (int k = 0; k < 3; k++) begin
            cyc(3);
            pulse_tick();
            checks++;
            if (N !== WIDTH'(exp_seq[k] >> FSZE) || mf !== WIDTH'(exp_seq[k] % 8)) begin
                errors++;
                $display("FAIL ramp_down_step%0d: N=%0h mf=%0h required N=%0h mf=%0h",
                         k, N, mf, exp_seq[k] >> FSZE, exp_seq[k] % 8);
            end
        end
        checks++;
        if (at_target !== 1'b1) begin
            errors++;
            $display("FAIL ramp_down_done: at_target=%0b required 1", at_target);
        end
        model_cur = 'h03;
    endtask

    task automatic test_handshake();
        int e;
        issue('h80, 'h40, DMAX);
        cmd.cmd_valid  = 1'b1;
        cmd.cmd_target = 17'h10;
        cmd.cmd_step   = 17'h08;
        cmd.duty_max   = 17'h1FFFF;
        checks++;
        if (cmd.cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL hs_load_ready: got %0b required 0", cmd.cmd_ready);
        end
        cyc(2);
        pulse_tick();
        checks++;
        if (N !== 17'h08 || mf !== 17'd3 || cmd.cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL hs_held_cmd: N=%0h mf=%0h rdy=%0b required 8 3 0", N, mf, cmd.cmd_ready);
        end
        cyc(2);
        pulse_tick();
        checks++;
        if (N !== 17'h10 || mf !== 17'd0 || cmd.cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL hs_converge: N=%0h mf=%0h rdy=%0b required 10 0 1", N, mf, cmd.cmd_ready);
        end
        // accept edge with a coincident tick, then a tick held through LOAD
        period_tick = 1'b1;
        cyc(1);
        checks++;
        if (N !== 17'h10 || mf !== 17'd0 || cmd.cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL hs_accept_tick: N=%0h mf=%0h rdy=%0b required 10 0 0", N, mf, cmd.cmd_ready);
        end
        cmd.cmd_valid = 1'b0;
        cyc(1);
        checks++;
        if (N !== 17'h10 || mf !== 17'd0) begin
            errors++;
            $display("FAIL hs_load_tick: N=%0h mf=%0h required 10 0", N, mf);
        end
        cyc(1);
        period_tick = 1'b0;
        checks++;
        if (N !== 17'h0F || mf !== 17'd0) begin
            errors++;
            $display("FAIL hs_first_ramp: N=%0h mf=%0h required f 0", N, mf);
        end
        for (int k = 2; k <= ticks_needed('h80, 'h10, 8); k++) begin
            cyc($urandom_range(1, 3));
            pulse_tick();
            e = exp_after('h80, 'h10, 8, k);
            checks++;
            if (N !== WIDTH'(e >> FSZE) || mf !== WIDTH'(e % 8)) begin
                errors++;
                $display("FAIL hs_ramp%0d: N=%0h mf=%0h required N=%0h mf=%0h", k, N, mf, e >> FSZE, e % 8);
            end
        end
        checks++;
        if (at_target !== 1'b1) begin
            errors++;
            $display("FAIL hs_done: at_target=%0b required 1", at_target);
        end
        model_cur = 'h10;
    endtask

    task automatic test_reset_mid_ramp();
        int e;
        issue('h50, 'h0C, DMAX);
        for (int k = 1; k <= 3; k++) begin
            cyc(19);
            pulse_tick();
            e = exp_after(model_cur, 'h50, 'h0C, k);
            checks++;
            if (N !== WIDTH'(e >> FSZE) || mf !== WIDTH'(e % 8)) begin
                errors++;
                $display("FAIL midrst_step%0d: N=%0h mf=%0h required N=%0h mf=%0h", k, N, mf, e >> FSZE, e % 8);
            end
        end
        sync_rst = 1'b1;
        cyc(1);
        sync_rst = 1'b0;
        checks++;
        if (N !== '0 || mf !== '0 || at_target !== 1'b1) begin
            errors++;
            $display("FAIL midrst_zero: N=%0h mf=%0h at=%0b required 0 0 1", N, mf, at_target);
        end
        cyc(2);
        pulse_tick();
        cyc(2);
        pulse_tick();
        checks++;
        if (N !== '0 || mf !== '0) begin
            errors++;
            $display("FAIL midrst_discard: N=%0h mf=%0h required 0 0", N, mf);
        end
        model_cur = 0;
    endtask

    task automatic test_random();
        int t, s, m, te, n, c0, e;
        for (int it = 0; it < 12; it++) begin
            t  = $urandom_range(0, DMAX);
            m  = $urandom_range(0, DMAX);
            s  = ($urandom_range(0, 4) == 0) ? 0 : $urandom_range('h800, DMAX);
            te = (t > m) ? m : t;
            c0 = model_cur;
            n  = ticks_needed(c0, te, s);
            issue(t, s, m);
            checks++;
            if (clamped !== (t > m)) begin
                errors++;
                $display("FAIL rand_clamped%0d: got %0b required %0b", it, clamped, t > m);
            end
            for (int k = 1; k <= n; k++) begin
                cyc($urandom_range(1, 4));
                pulse_tick();
                e = exp_after(c0, te, s, k);
                checks++;
                if (N !== WIDTH'(e >> FSZE) || mf !== WIDTH'(e % 8) || at_target !== (k == n)) begin
                    errors++;
                    $display("FAIL rand%0d_tick%0d: N=%0h mf=%0h at=%0b required N=%0h mf=%0h at=%0b",
                             it, k, N, mf, at_target, e >> FSZE, e % 8, k == n);
                end
            end
            cyc(1);
            checks++;
            if (N !== WIDTH'(te >> FSZE) || mf !== WIDTH'(te % 8) || at_target !== 1'b1) begin
                errors++;
                $display("FAIL rand%0d_settled: N=%0h mf=%0h at=%0b required N=%0h mf=%0h at=1",
                         it, N, mf, at_target, te >> FSZE, te % 8);
            end
            model_cur = te;
        end
    endtask

    initial begin
        cmd.cmd_valid  = 1'b0;
        cmd.cmd_target = '0;
        cmd.cmd_step   = '0;
        cmd.duty_max   = '0;
        test_reset();
        test_ramp_up();
        test_clamp();
        test_ramp_down();
        test_handshake();
        test_reset_mid_ramp();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
